ifetch_bp: RTL

Instruction fetch stage with branch prediction for the 4-stage core. It sits directly upstream of instruction decode. It owns the fetch PC, issues requests to instruction memory with a request/ack handshake, and predicts the next PC from a 2-bit-counter branch history table with targets (BHT/BTB). It loads the IF/ID register (`instr`, `pc_if2id`, `wr_addr`, `opcode`) and flushes it to a NOP on redirects from execute.

---
 rtl/ifetch_pkg.sv | 32 +++
 rtl/if_bht.sv | 63 ++++++
 rtl/ifetch_bp.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the fetch stage and its branch history table.
// Used by ifetch_bp and if_bht (if_bht is only built when IFETCH_BPRED_EN is defined).
package ifetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    RST     = 2'd0,
    REQ     = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } fetch_state_e;

  // Tag is kept full-width so the entry type does not depend on the table size.
  typedef struct packed {
    logic        valid;
    logic [31:0] tag;
    logic [1:0]  ctr;
    logic [31:0] target;
  } bht_entry_t;

  function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic up);
    logic [1:0] res;
    if (up) begin
      res = (ctr == 2'b11) ? ctr : ctr + 2'd1;
    end else begin
      res = (ctr == 2'b00) ? ctr : ctr - 2'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/if_bht.sv
// Branch history table with targets: combinational lookup, synchronous update.
// Instantiated by ifetch_bp only when IFETCH_BPRED_EN is defined.
module if_bht
  import ifetch_pkg::*;
#(
  parameter int BHT_IDX = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] lookup_pc_i,
  output logic        pred_taken_o,
  output logic [31:0] pred_target_o,
  input  logic        upd_valid_i,
  input  logic [31:0] upd_pc_i,
  input  logic        upd_taken_i,
  input  logic [31:0] upd_target_i
);

  localparam int ENTRIES = 1 << BHT_IDX;

  bht_entry_t         bht_q [ENTRIES];
  bht_entry_t         look_ent;
  bht_entry_t         upd_ent;
  logic [BHT_IDX-1:0] look_idx;
  logic [BHT_IDX-1:0] upd_idx;
  logic [31:0]        look_tag;
  logic [31:0]        upd_tag;
  logic               upd_hit;
  logic               unused_bits;

  assign look_idx = lookup_pc_i[BHT_IDX+1:2];
  assign upd_idx  = upd_pc_i[BHT_IDX+1:2];
  assign look_tag = lookup_pc_i >> (BHT_IDX + 2);
  assign upd_tag  = upd_pc_i >> (BHT_IDX + 2);

  assign look_ent = bht_q[look_idx];
  assign upd_ent  = bht_q[upd_idx];
  assign upd_hit  = upd_ent.valid && (upd_ent.tag == upd_tag);

  assign pred_taken_o  = look_ent.valid && (look_ent.tag == look_tag) && look_ent.ctr[1];
  assign pred_target_o = look_ent.target;

  assign unused_bits = ^{lookup_pc_i[1:0], upd_pc_i[1:0]};

  // A not-taken miss never allocates, so cold branches keep falling through.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < ENTRIES; i++) begin
        bht_q[i] <= '{valid: 1'b0, tag: '0, ctr: 2'b01, target: '0};
      end
    end else if (upd_valid_i) begin
      if (upd_hit) begin
        bht_q[upd_idx].ctr <= ctr_step(upd_ent.ctr, upd_taken_i);
        if (upd_taken_i) begin
          bht_q[upd_idx].target <= upd_target_i;
        end
      end else if (upd_taken_i) begin
        bht_q[upd_idx] <= '{valid: 1'b1, tag: upd_tag, ctr: 2'b10, target: upd_target_i};
      end
    end
  end

endmodule

// File: rtl/ifetch_bp.sv
// Fetch stage: owns the fetch PC, runs the imem req/ack handshake and loads IF/ID.
// IFETCH_BPRED_EN enables the BHT/BTB predictor; otherwise fetch is always sequential.
module ifetch_bp
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          BHT_IDX  = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        ide_wait,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] pc_if2id,
  output logic [4:0]  wr_addr,
  output logic [6:0]  opcode,
  output logic        pred_taken,
  output logic [31:0] pred_target
);

  fetch_state_e state_q, state_d;
  logic [31:0]  fpc_q, fpc_d;
  logic [31:0]  skid_q, skid_d;
  logic [31:0]  daddr_q, daddr_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pc_q, pc_d;
  logic         ptk_q, ptk_d;
  logic [31:0]  ptgt_q, ptgt_d;
  logic         bht_taken;
  logic [31:0]  bht_target;
  logic [31:0]  next_pc;

`ifdef IFETCH_BPRED_EN
  if_bht #(.BHT_IDX(BHT_IDX)) u_bht (
    .clk          (clk),
    .rstn         (rstn),
    .lookup_pc_i  (fpc_q),
    .pred_taken_o (bht_taken),
    .pred_target_o(bht_target),
    .upd_valid_i  (upd_valid),
    .upd_pc_i     (upd_pc),
    .upd_taken_i  (upd_taken),
    .upd_target_i (upd_target)
  );
`else
  logic               unused_upd;
  logic [BHT_IDX-1:0] unused_idx;
  assign unused_upd = ^{upd_valid, upd_pc, upd_taken, upd_target};
  assign unused_idx = fpc_q[BHT_IDX+1:2];
  assign bht_taken  = 1'b0;
  assign bht_target = '0;
`endif

  assign next_pc = bht_taken ? bht_target : fpc_q + 32'd4;

  // DISCARD keeps presenting the old address so the outstanding request stays stable.
  always_comb begin
    state_d = state_q;
    fpc_d   = fpc_q;
    skid_d  = skid_q;
    daddr_d = daddr_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    ptk_d   = ptk_q;
    ptgt_d  = ptgt_q;
    case (state_q)
      RST: state_d = REQ;
      REQ: begin
        if (imem_ack && !ide_wait) begin
          instr_d = imem_rdata;
          pc_d    = fpc_q;
          ptk_d   = bht_taken;
          ptgt_d  = next_pc;
          fpc_d   = next_pc;
        end else if (imem_ack) begin
          skid_d  = imem_rdata;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (!ide_wait) begin
          instr_d = skid_q;
          pc_d    = fpc_q;
          ptk_d   = bht_taken;
          ptgt_d  = next_pc;
          fpc_d   = next_pc;
          state_d = REQ;
        end
      end
      DISCARD: begin
        if (imem_ack) state_d = REQ;
      end
      default: state_d = RST;
    endcase
    // A request still waiting for its ack must run to completion before the next one.
    if (redirect) begin
      fpc_d   = redirect_pc;
      instr_d = NOP_INSTR;
      pc_d    = '0;
      ptk_d   = 1'b0;
      ptgt_d  = '0;
      if (state_q == REQ && !imem_ack) begin
        state_d = DISCARD;
        daddr_d = fpc_q;
      end else if (state_q == DISCARD && !imem_ack) begin
        state_d = DISCARD;
      end else begin
        state_d = REQ;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= RST;
      fpc_q   <= RESET_PC;
      skid_q  <= '0;
      daddr_q <= '0;
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
      ptk_q   <= 1'b0;
      ptgt_q  <= '0;
    end else begin
      state_q <= state_d;
      fpc_q   <= fpc_d;
      skid_q  <= skid_d;
      daddr_q <= daddr_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      ptk_q   <= ptk_d;
      ptgt_q  <= ptgt_d;
    end
  end

  assign imem_req    = (state_q == REQ) || (state_q == DISCARD);
  assign imem_addr   = (state_q == DISCARD) ? daddr_q : fpc_q;
  assign instr       = instr_q;
  assign pc_if2id    = pc_q;
  assign wr_addr     = instr_q[11:7];
  assign opcode      = instr_q[6:0];
  assign pred_taken  = ptk_q;
  assign pred_target = ptgt_q;

endmodule
